// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM states, well-known
// scan-code prefixes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  // PS/2 frames use odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, run-length glitch filter and registered falling-edge
// strobe for the PS/2 device clock. Idle/reset level is high.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          prev_q, prev_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    // cnt_q counts consecutive samples disagreeing with the filtered level;
    // the level flips on the FILTER_LEN-th such sample.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d = filt_q;
    fall_d = prev_q & ~filt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: samples 11-bit device frames on filtered clock falls, checks
// start/parity/stop and inter-edge timeout, and presents each good byte.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       valid,
  output logic       frame_err,
  output ps2_state_e dbg_state
);

  localparam int TO_LIMIT = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT) + 1;

  // valid/frame_err are single-cycle pulses with no backpressure: a consumer
  // must take scan_code in the cycle valid is high (it then holds until the
  // next good frame anyway).

  logic            fall_stb;
  logic [1:0]      dsync_q, dsync_d;
  logic            data_s;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            timeout;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ps2_clk),
    .fall (fall_stb)
  );

  assign data_s  = dsync_q[1];
  assign timeout = (to_cnt_q == TO_W'(TO_LIMIT));

  always_comb begin
    dsync_d   = {dsync_q[0], ps2_data};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (state_q == IDLE || fall_stb) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (fall_stb && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall_stb) begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall_stb) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_stb) begin
          state_d = IDLE;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            code_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge arriving in the same cycle as the timeout keeps the frame alive.
    if (state_q != IDLE && !fall_stb && timeout) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dsync_q   <= 2'b11;
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dsync_q   <= dsync_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign scan_code = code_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign dbg_state = state_q;

endmodule
